leg_divider: RTL and testbench

- Programmable clock divider that produces the slow square-wave strobe driving the goose-leg animation toggle.
- Sits between the system/pixel clock domain and the sprite-draw logic.
- Also emits a single-cycle rising-edge tick, so downstream logic can run on the fast clock instead of the divided one.

---
 rtl/leg_divider_pkg.sv | 12 +
 rtl/leg_div_counter.sv | 27 ++
 rtl/leg_divider.sv | 53 +++++
 tb/tb_leg_divider.sv | 104 ++++++++++
 4 files changed

// File: rtl/leg_divider_pkg.sv
// Shared constants and helpers for the goose-leg animation clock divider.
package leg_divider_pkg;

    // Half-period defaults for a 5 Hz leg strobe on each board clock
    localparam int LEG_HALF_100M = 10_000_000;
    localparam int LEG_HALF_25M  = 2_500_000;

    function automatic int leg_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/leg_div_counter.sv
// Modulo-MOD up-counter with enable and synchronous clear; flags the terminal value.
module leg_div_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic         w_tc;

    assign w_tc  = (r_cnt == W'(MOD - 1));
    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

    always_ff @(posedge i_clk) begin
        if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= w_tc ? '0 : r_cnt + W'(1);
    end

endmodule

// File: rtl/leg_divider.sv
// Programmable divider producing the leg-animation square wave plus a rise tick
// usable as a fast-clock enable.
module leg_divider
    import leg_divider_pkg::*;
#(
    parameter int HALF_PERIOD = LEG_HALF_100M
) (
    input  logic clk_leg,
    input  logic reset,
    input  logic en,
    output logic clk_out,
    output logic tick
);

    localparam int CNT_W = leg_cnt_w(HALF_PERIOD);

    if (HALF_PERIOD < 1) begin : g_bad_half_period
        $error("leg_divider: HALF_PERIOD must be >= 1");
    end

    logic [CNT_W-1:0] w_cnt;
    logic             w_tc;
    logic             r_clk_out;
    logic             r_tick;

    leg_div_counter #(
        .MOD (HALF_PERIOD),
        .W   (CNT_W)
    ) u_cnt (
        .i_clk (clk_leg),
        .i_clr (reset),
        .i_en  (en),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // Toggle only on an enabled terminal cycle; tick marks the 0->1 edge
    always_ff @(posedge clk_leg) begin
        if (reset) begin
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (en && w_tc) begin
            r_clk_out <= ~r_clk_out;
            r_tick    <= ~r_clk_out;
        end else begin
            r_tick    <= 1'b0;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule

// File: tb/tb_leg_divider.sv
// Scoreboard bench for leg_divider at HALF_PERIOD 4, 1 and 3.
module tb_leg_divider;

    logic       clk_leg = 1'b0;
    logic [2:0] rst_v   = 3'b111;
    logic [2:0] en_v    = 3'b000;
    logic [2:0] co;
    logic [2:0] tk;

    always #5 clk_leg = ~clk_leg;

    leg_divider #(.HALF_PERIOD(4)) dut_a (
        .clk_leg (clk_leg), .reset (rst_v[0]), .en (en_v[0]), .clk_out (co[0]), .tick (tk[0]));
    leg_divider #(.HALF_PERIOD(1)) dut_b (
        .clk_leg (clk_leg), .reset (rst_v[1]), .en (en_v[1]), .clk_out (co[1]), .tick (tk[1]));
    leg_divider #(.HALF_PERIOD(3)) dut_c (
        .clk_leg (clk_leg), .reset (rst_v[2]), .en (en_v[2]), .clk_out (co[2]), .tick (tk[2]));

    typedef struct {
        int id;
        int cnt;
        bit clk;
        bit tck;
    } exp_t;

    exp_t sb[$];
    int   hp[3] = '{4, 1, 3};
    int   n_en[3] = '{0, 0, 0};
    int   n_chk = 0;
    int   n_err = 0;
    int   tick_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s obs=%0d exp=%0d @%0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int obs_cnt(input int id);
        case (id)
            0:       return int'(dut_a.w_cnt);
            1:       return int'(dut_b.w_cnt);
            default: return int'(dut_c.w_cnt);
        endcase
    endfunction

    // Model: outputs follow from the number of enabled cycles since reset
    task automatic cyc(input int id, input bit r, input bit e);
        exp_t x;
        rst_v[id] = r;
        en_v[id]  = e;
        @(posedge clk_leg);
        if (r) n_en[id] = 0;
        else if (e) n_en[id]++;
        x.id  = id;
        x.cnt = n_en[id] % hp[id];
        x.clk = ((n_en[id] / hp[id]) % 2) == 1;
        x.tck = !r && e && ((n_en[id] % (2 * hp[id])) == hp[id]);
        sb.push_back(x);
        @(negedge clk_leg);
        x = sb.pop_front();
        chk($sformatf("d%0d clk_out", x.id), 32'(co[x.id]), 32'(x.clk));
        chk($sformatf("d%0d tick", x.id), 32'(tk[x.id]), 32'(x.tck));
        chk($sformatf("d%0d cnt", x.id), 32'(obs_cnt(x.id)), 32'(x.cnt));
        if (tk[x.id]) tick_seen++;
    endtask

    initial begin
        // HALF_PERIOD=4: reset, then free run (ticks at 4, 12, 20)
        repeat (2) cyc(0, 1'b1, 1'b0);
        repeat (20) cyc(0, 1'b0, 1'b1);
        // freeze at cnt=2 for 5 cycles
        cyc(0, 1'b1, 1'b0);
        repeat (2) cyc(0, 1'b0, 1'b1);
        repeat (5) cyc(0, 1'b0, 1'b0);
        repeat (4) cyc(0, 1'b0, 1'b1);
        // reset at cnt=3 with clk_out=1, en held high
        cyc(0, 1'b1, 1'b0);
        repeat (7) cyc(0, 1'b0, 1'b1);
        cyc(0, 1'b1, 1'b1);
        repeat (6) cyc(0, 1'b0, 1'b1);
        repeat (40) cyc(0, ($urandom_range(15) == 0), 1'($urandom_range(1)));
        rst_v[0] = 1'b1;

        // HALF_PERIOD=1: divide-by-2
        repeat (2) cyc(1, 1'b1, 1'b0);
        repeat (6) cyc(1, 1'b0, 1'b1);
        repeat (20) cyc(1, ($urandom_range(15) == 0), 1'($urandom_range(1)));
        rst_v[1] = 1'b1;

        // HALF_PERIOD=3: odd half period, two ticks in 12 cycles
        repeat (2) cyc(2, 1'b1, 1'b0);
        tick_seen = 0;
        repeat (12) cyc(2, 1'b0, 1'b1);
        chk("d2 tick count", 32'(tick_seen), 32'd2);
        repeat (30) cyc(2, ($urandom_range(15) == 0), 1'($urandom_range(1)));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
